lsu_pipe: RTL and testbench

- Parametrised, multi-cycle load/store unit that replaces the purely combinational memory-access stage.
- Accepts one load/store per handshake from the execute stage and drives a request/grant/response data bus.
- Handles bus wait states, misalignment and bus errors.
- Returns aligned, sign- or zero-extended load data, tagged with the destination register, to writeback.

---
 rtl/lsu_pipe_pkg.sv | 18 +
 rtl/lsu_align.sv | 38 +++
 rtl/lsu_pipe.sv | 138 +++++++++++++
 tb/tb_lsu_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pipe_pkg.sv
// lsu_pipe_pkg: shared size, cause and state encodings for the load/store unit
package lsu_pipe_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] CAUSE_OK       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction/extension for loads
module lsu_align
    import lsu_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [1:0]      size,
    input  logic [OW-1:0]   off,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] lane_wdata,
    output logic [XLEN-1:0] load_data
);
    logic [3:0]      nbytes;
    logic [7:0]      mask;
    logic [XLEN-1:0] shifted;
    logic            sign;

    always_comb begin
        nbytes = size_bytes(size);
        mask = 8'((9'd1 << nbytes) - 9'd1);
        be = NB'(mask) << off;
        shifted = rdata >> {off, 3'b000};
        sign = !uns && (size == SZ_B ? shifted[7] : size == SZ_H ? shifted[15] :
                        size == SZ_D ? shifted[XLEN-1] : shifted[31]);
        // replicate the low store bytes into every lane so the slave picks its own
        for (int i = 0; i < NB; i++) begin
            lane_wdata[8*i +: 8] = wdata[8*(i & (int'(nbytes) - 1)) +: 8];
        end
        for (int b = 0; b < XLEN; b++) begin
            load_data[b] = b < 8 * int'(nbytes) ? shifted[b] : sign;
        end
    end
endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: multi-cycle load/store unit on a request/grant/response bus
module lsu_pipe
    import lsu_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW = 32,
    parameter int TIMEOUT = 255,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB),
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_store_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_wreg_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic [1:0]      resp_cause_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [AW-1:0]   bus_addr_o,
    output logic [NB-1:0]   bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i
);
    state_t          state, state_n;
    logic            store, uns, flushed, flushed_n;
    logic [1:0]      size, cause;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata, data, lane_wdata, load_data;
    logic [4:0]      rd;
    logic [CW-1:0]   cnt;
    logic [NB-1:0]   be;
    logic [3:0]      nb_req;
    logic            accept, bad, tmo;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size      (size),
        .off       (addr[OW-1:0]),
        .uns       (uns),
        .wdata     (wdata),
        .rdata     (bus_rdata_i),
        .be        (be),
        .lane_wdata(lane_wdata),
        .load_data (load_data)
    );

    assign nb_req = size_bytes(req_size_i);
    assign accept = state == IDLE && req_valid_i && !flush_i;
    assign bad = |(req_addr_i[2:0] & 3'(nb_req - 4'd1)) || (req_size_i == SZ_D && XLEN == 32);
    assign tmo = (TIMEOUT != 0) && (int'(cnt) + 1 >= TIMEOUT);

    always_comb begin
        state_n = state;
        flushed_n = flushed;
        case (state)
            IDLE: if (accept) begin
                state_n = bad ? DONE : REQ;
                flushed_n = 1'b0;
            end
            REQ: begin
                // a granted access must still drain its response even when flushed
                if (bus_gnt_i) begin
                    state_n = RSP;
                    flushed_n = flush_i;
                end else if (flush_i) state_n = IDLE;
                else if (tmo) state_n = DONE;
            end
            RSP: begin
                flushed_n = flushed | flush_i;
                if (bus_rvalid_i || tmo) state_n = flushed_n ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            flushed <= 1'b0;
            cnt <= '0;
            store <= 1'b0;
            uns <= 1'b0;
            size <= SZ_B;
            cause <= CAUSE_OK;
            addr <= '0;
            wdata <= '0;
            data <= '0;
            rd <= '0;
        end else begin
            state <= state_n;
            flushed <= flushed_n;
            if (accept) begin
                store <= req_store_i;
                size <= req_size_i;
                uns <= req_unsigned_i;
                addr <= req_addr_i;
                wdata <= req_wdata_i;
                rd <= req_rd_i;
                cnt <= '0;
                cause <= bad ? CAUSE_MISALIGN : CAUSE_OK;
                data <= '0;
            end
            if (state == REQ || state == RSP) cnt <= cnt + CW'(1);
            if (state == RSP && bus_rvalid_i) begin
                cause <= bus_err_i ? CAUSE_BUSERR : CAUSE_OK;
                data <= (store || bus_err_i) ? '0 : load_data;
            end else if (tmo && ((state == REQ && !bus_gnt_i) || state == RSP)) begin
                cause <= CAUSE_TIMEOUT;
                data <= '0;
            end
        end
    end

    assign req_ready_o = state == IDLE && !flush_i;
    assign resp_valid_o = state == DONE && !flushed && !flush_i;
    assign resp_rd_o = resp_valid_o ? rd : '0;
    assign resp_wreg_o = resp_valid_o && !store && cause == CAUSE_OK;
    assign resp_data_o = resp_valid_o ? data : '0;
    assign resp_cause_o = resp_valid_o ? cause : CAUSE_OK;
    assign bus_req_o = state == REQ;
    assign bus_we_o = bus_req_o && store;
    assign bus_addr_o = bus_req_o ? {addr[AW-1:OW], OW'(0)} : '0;
    assign bus_be_o = bus_req_o ? be : '0;
    assign bus_wdata_o = bus_we_o ? lane_wdata : '0;
endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: randomized and directed checks of lsu_pipe at XLEN 32 and 64
module tb_lsu_pipe;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst, sel;
    logic        req_valid, req_store, req_uns, flush, gnt, rvalid, err;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, rdata;
    logic [4:0]  req_rd;

    logic        a_ready, a_rv, a_wreg, a_breq, a_we;
    logic [4:0]  a_rd;
    logic [31:0] a_data, a_addr, a_wdata;
    logic [1:0]  a_cause;
    logic [3:0]  a_be;
    logic        b_ready, b_rv, b_wreg, b_breq, b_we;
    logic [4:0]  b_rd;
    logic [63:0] b_data, b_wdata;
    logic [31:0] b_addr;
    logic [1:0]  b_cause;
    logic [7:0]  b_be;

    logic        v_ready, v_rv, v_wreg, v_breq, v_we;
    logic [4:0]  v_rd;
    logic [63:0] v_data, v_wdata;
    logic [31:0] v_addr;
    logic [1:0]  v_cause;
    logic [7:0]  v_be;

    int assertions = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_pipe #(.XLEN(32), .AW(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid & ~sel), .req_ready_o(a_ready), .req_store_i(req_store),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .req_rd_i(req_rd), .flush_i(flush & ~sel),
        .resp_valid_o(a_rv), .resp_rd_o(a_rd), .resp_wreg_o(a_wreg), .resp_data_o(a_data),
        .resp_cause_o(a_cause), .bus_req_o(a_breq), .bus_we_o(a_we), .bus_addr_o(a_addr),
        .bus_be_o(a_be), .bus_wdata_o(a_wdata), .bus_gnt_i(gnt & ~sel),
        .bus_rvalid_i(rvalid & ~sel), .bus_rdata_i(rdata[31:0]), .bus_err_i(err)
    );

    lsu_pipe #(.XLEN(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid & sel), .req_ready_o(b_ready), .req_store_i(req_store),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd), .flush_i(flush & sel),
        .resp_valid_o(b_rv), .resp_rd_o(b_rd), .resp_wreg_o(b_wreg), .resp_data_o(b_data),
        .resp_cause_o(b_cause), .bus_req_o(b_breq), .bus_we_o(b_we), .bus_addr_o(b_addr),
        .bus_be_o(b_be), .bus_wdata_o(b_wdata), .bus_gnt_i(gnt & sel),
        .bus_rvalid_i(rvalid & sel), .bus_rdata_i(rdata), .bus_err_i(err)
    );

    assign v_ready = sel ? b_ready : a_ready;
    assign v_rv    = sel ? b_rv : a_rv;
    assign v_wreg  = sel ? b_wreg : a_wreg;
    assign v_breq  = sel ? b_breq : a_breq;
    assign v_we    = sel ? b_we : a_we;
    assign v_rd    = sel ? b_rd : a_rd;
    assign v_cause = sel ? b_cause : a_cause;
    assign v_addr  = sel ? b_addr : a_addr;
    assign v_data  = sel ? b_data : {32'b0, a_data};
    assign v_wdata = sel ? b_wdata : {32'b0, a_wdata};
    assign v_be    = sel ? b_be : {4'b0, a_be};

    // Reference: byte arithmetic straight from the access rules
    function automatic void model(input int xl, input logic [1:0] sz, input bit un,
                                  input logic [31:0] ad, input logic [63:0] wd, input logic [63:0] rd,
                                  output bit mis, output logic [7:0] be,
                                  output logic [63:0] lane, output logic [63:0] ld);
        int nb, nbus, off;
        logic [63:0] mask, v;
        nb = 1 << sz;
        nbus = xl / 8;
        off = int'(ad[5:0]) % nbus;
        mis = (int'(ad[5:0]) % nb != 0) || (sz == 2'd3 && xl == 32);
        be = 8'(((1 << nb) - 1) << off);
        lane = '0;
        for (int i = 0; i < nbus; i++) lane[8*i +: 8] = wd[8*(i % nb) +: 8];
        mask = (nb == 8) ? '1 : (64'd1 << (8 * nb)) - 64'd1;
        v = (rd >> (8 * off)) & mask;
        if (!un && v[8*nb-1]) v = v | ~mask;
        ld = (xl == 32) ? (v & 64'hFFFF_FFFF) : v;
    endfunction

    // fl: 0 none, 1 flush in REQ before grant, 2 flush in first RSP cycle
    task automatic access(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] ad,
                          input logic [63:0] wd, input logic [63:0] rdat, input int gw, input int rw,
                          input bit er, input int fl, input bit nogrant, input string nm);
        bit mis, done, gotresp, rvgiven, stable;
        int xl, lat, olat, reqn, rspn, explat;
        logic [7:0] ebe, cbe;
        logic [63:0] elane, eld, edata, cwd, odata;
        logic [31:0] eaddr, caddr;
        logic [1:0] ecause, ocause;
        logic [4:0] rdn, ord;
        logic cwe, owreg;
        xl = sel ? 64 : 32;
        model(xl, sz, un, ad, wd, rdat, mis, ebe, elane, eld);
        ecause = mis ? 2'd1 : nogrant ? 2'd3 : er ? 2'd2 : 2'd0;
        edata = (st || ecause != 2'd0) ? 64'd0 : eld;
        eaddr = ad & ~32'(xl / 8 - 1);
        explat = mis ? 1 : nogrant ? TMO + 1 : gw + rw + 3;
        rdn = 5'($urandom);
        done = 0; gotresp = 0; rvgiven = 0; stable = 1;
        lat = 0; olat = 0; reqn = 0; rspn = 0;
        cbe = 0; cwd = 0; caddr = 0; cwe = 0; odata = 0; ocause = 0; ord = 0; owreg = 0;
        @(negedge clk);
        req_valid = 1; req_store = st; req_size = sz; req_uns = un;
        req_addr = ad; req_wdata = wd; req_rd = rdn;
        #1;
        assertions++;
        if (v_ready !== 1'b1) begin failures++; $display("FAIL %s ready: got %b expected 1", nm, v_ready); end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            req_valid = 0; gnt = 0; rvalid = 0; err = 0; flush = 0;
            rdata = {$urandom, $urandom};
            #1;
            lat++;
            if (v_rv) begin
                gotresp = 1; done = 1; olat = lat;
                odata = v_data; ocause = v_cause; ord = v_rd; owreg = v_wreg;
            end else if (v_ready) done = 1;
            else if (v_breq) begin
                reqn++;
                if (reqn == 1) begin caddr = v_addr; cbe = v_be; cwd = v_wdata; cwe = v_we; end
                else if ({caddr, cbe, cwd, cwe} !== {v_addr, v_be, v_wdata, v_we}) stable = 0;
                if (fl == 1 && reqn == 2) flush = 1;
                else if (!nogrant && reqn > gw) gnt = 1;
            end else begin
                rspn++;
                if (fl == 2 && rspn == 1) flush = 1;
                if (rspn > rw) begin rvalid = 1; err = er; rdata = rdat; rvgiven = 1; end
            end
        end
        assertions++;
        if (!done) begin failures++; $display("FAIL %s completion: got none within 40 cycles expected done", nm); end
        if (fl == 0) begin
            assertions++;
            if (!gotresp) begin failures++; $display("FAIL %s resp_valid: got 0 expected 1", nm); end
            assertions++;
            if (olat != explat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", nm, olat, explat); end
            assertions++;
            if (ocause !== ecause) begin failures++; $display("FAIL %s cause: got %0d expected %0d", nm, ocause, ecause); end
            assertions++;
            if (odata !== edata) begin failures++; $display("FAIL %s data: got %h expected %h", nm, odata, edata); end
            assertions++;
            if (owreg !== (!st && ecause == 2'd0)) begin failures++; $display("FAIL %s wreg: got %b expected %b", nm, owreg, !st && ecause == 2'd0); end
            assertions++;
            if (ord !== rdn) begin failures++; $display("FAIL %s rd: got %0d expected %0d", nm, ord, rdn); end
            @(negedge clk);
            #1;
            assertions++;
            if (v_rv !== 1'b0 || v_ready !== 1'b1) begin failures++; $display("FAIL %s pulse: got rv=%b ready=%b expected rv=0 ready=1", nm, v_rv, v_ready); end
        end else begin
            assertions++;
            if (gotresp) begin failures++; $display("FAIL %s flushed resp_valid: got 1 expected 0", nm); end
            if (fl == 2) begin
                assertions++;
                if (!rvgiven) begin failures++; $display("FAIL %s idle before rvalid: got early idle expected wait", nm); end
            end
        end
        if (mis) begin
            assertions++;
            if (reqn != 0) begin failures++; $display("FAIL %s bus_req cycles: got %0d expected 0", nm, reqn); end
        end else begin
            assertions++;
            if ({caddr, cbe, cwe} !== {eaddr, ebe, st}) begin
                failures++; $display("FAIL %s bus addr/be/we: got %h/%h/%b expected %h/%h/%b", nm, caddr, cbe, cwe, eaddr, ebe, st);
            end
            if (st) begin
                assertions++;
                if (cwd !== elane) begin failures++; $display("FAIL %s bus_wdata: got %h expected %h", nm, cwd, elane); end
            end
            assertions++;
            if (!stable) begin failures++; $display("FAIL %s bus stability: got change expected stable", nm); end
            if (nogrant) begin
                assertions++;
                if (reqn != TMO) begin failures++; $display("FAIL %s timeout req cycles: got %0d expected %0d", nm, reqn, TMO); end
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            assertions++;
            if ({v_ready, v_rv, v_breq, v_we, v_wreg, v_cause, v_rd, v_be, v_addr, v_data, v_wdata} !== {1'b1, 179'd0}) begin
                failures++;
                $display("FAIL reset outputs xlen%0d: got ready=%b rv=%b breq=%b be=%h data=%h expected ready=1 rest 0",
                         s ? 64 : 32, v_ready, v_rv, v_breq, v_be, v_data);
            end
        end
        @(negedge clk);
        rst = 0;
        sel = 0;
    endtask

    task automatic test_directed32;
        access(0, 2'd0, 0, 32'h1003, 64'd0, 64'h80AB_CDEF, 0, 0, 0, 0, 0, "lb_sign");
        access(1, 2'd1, 0, 32'h2002, 64'h1234_BEEF, 64'd0, 0, 0, 0, 0, 0, "sh_lanes");
        access(0, 2'd2, 0, 32'h0001, 64'd0, 64'd0, 0, 0, 0, 0, 0, "lw_misaligned");
        access(0, 2'd3, 0, 32'h0008, 64'd0, 64'd0, 0, 0, 0, 0, 0, "ld_illegal32");
        access(0, 2'd1, 1, 32'h0102, 64'd0, 64'h8001_7FFF, 0, 0, 0, 0, 0, "lhu");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            access(0, 2'd2, 0, 32'h400 + 32'(4 * i), 64'd0, {32'd0, $urandom}, 0, 0, 0, 0, 0, "b2b");
    endtask

    task automatic test_wait_err;
        access(0, 2'd2, 0, 32'h0040, 64'd0, 64'h1234_5678, 3, 0, 1, 0, 0, "wait_buserr");
        access(1, 2'd0, 0, 32'h0041, 64'h55, 64'd0, 2, 2, 0, 0, 0, "wait_store");
    endtask

    task automatic test_timeout;
        access(0, 2'd2, 0, 32'h0080, 64'd0, 64'd0, 0, 0, 0, 0, 1, "timeout");
    endtask

    task automatic test_late_rvalid;
        @(negedge clk);
        rvalid = 1; err = 1; rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 0; err = 0;
        #1;
        assertions++;
        if (v_rv !== 1'b0 || v_breq !== 1'b0 || v_ready !== 1'b1) begin
            failures++; $display("FAIL late_rvalid: got rv=%b breq=%b ready=%b expected 0/0/1", v_rv, v_breq, v_ready);
        end
    endtask

    task automatic test_flush;
        access(0, 2'd2, 0, 32'h0300, 64'd0, 64'd0, 3, 0, 0, 1, 0, "flush_req");
        access(0, 2'd2, 0, 32'h0304, 64'd0, 64'h0BAD_F00D, 0, 2, 0, 2, 0, "flush_rsp");
        access(0, 2'd2, 0, 32'h0308, 64'd0, 64'hCAFE_0042, 0, 0, 0, 0, 0, "after_flush");
    endtask

    task automatic test_flush_idle;
        @(negedge clk);
        req_valid = 1; flush = 1; req_store = 0; req_size = 2'd2; req_addr = 32'h500;
        #1;
        assertions++;
        if (v_ready !== 1'b0) begin failures++; $display("FAIL flush_idle ready: got %b expected 0", v_ready); end
        @(negedge clk);
        req_valid = 0; flush = 0;
        #1;
        assertions++;
        if (v_breq !== 1'b0 || v_rv !== 1'b0 || v_ready !== 1'b1) begin
            failures++; $display("FAIL flush_idle accept: got breq=%b rv=%b ready=%b expected 0/0/1", v_breq, v_rv, v_ready);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1; req_store = 0; req_size = 2'd2; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 0;
        #1;
        assertions++;
        if (v_breq !== 1'b1) begin failures++; $display("FAIL reset_mid breq: got %b expected 1", v_breq); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        assertions++;
        if (v_ready !== 1'b1 || v_breq !== 1'b0) begin
            failures++; $display("FAIL reset_mid idle: got ready=%b breq=%b expected 1/0", v_ready, v_breq);
        end
        repeat (4) begin
            @(negedge clk);
            #1;
            if (v_rv) seen = 1;
        end
        assertions++;
        if (seen) begin failures++; $display("FAIL reset_mid resp_valid: got 1 expected 0"); end
    endtask

    task automatic test_random(input bit s, input int n);
        logic [1:0] sz;
        logic [31:0] ad;
        sel = s;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 9) < 7) ad = ad & ~32'((1 << sz) - 1);
            access(1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 9) == 0, 0, 0, "random");
        end
        sel = 0;
    endtask

    task automatic test_xlen64;
        sel = 1;
        access(0, 2'd2, 1, 32'h0000_1004, 64'd0, 64'hF000_0001_0000_0000, 0, 0, 0, 0, 0, "lwu64");
        access(1, 2'd3, 0, 32'h0000_2008, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 0, 0, 0, "sd64");
        access(0, 2'd2, 0, 32'h0000_3004, 64'd0, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 0, "lw64_sign");
        sel = 0;
    endtask

    initial begin
        rst = 1; sel = 0;
        req_valid = 0; req_store = 0; req_uns = 0; req_size = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        flush = 0; gnt = 0; rvalid = 0; err = 0; rdata = 0;
        test_reset;
        test_directed32;
        test_back_to_back;
        test_wait_err;
        test_timeout;
        test_late_rvalid;
        test_flush;
        test_flush_idle;
        test_reset_mid;
        test_random(0, 40);
        test_xlen64;
        test_random(1, 30);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global time limit: got no end expected finish");
        $fatal(1);
    end
endmodule
